// File: rtl/quad_cmd_pkg.sv
// Shared opcodes, response codes and arbiter types for the quad command path.
package quad_cmd_pkg;

   localparam logic [7:0] SET_PTCH  = 8'h02;
   localparam logic [7:0] SET_ROLL  = 8'h03;
   localparam logic [7:0] SET_YAW   = 8'h04;
   localparam logic [7:0] SET_THRST = 8'h05;
   localparam logic [7:0] CALIBRATE = 8'h06;
   localparam logic [7:0] EMER_LAND = 8'h07;
   localparam logic [7:0] MTRS_OFF  = 8'h08;

   localparam logic [7:0] POS_ACK = 8'hA5;
   localparam logic [7:0] NACK    = 8'h00;

   typedef enum logic [1:0] {NONE, HOST, AUX, FS} owner_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} arb_state_t;

endpackage

// File: rtl/cmd_wdog.sv
// Saturating silence counter: counts up every cycle, clears on activity,
// flags when it has sat at TERM_CYC.
module cmd_wdog #(
   parameter int unsigned TERM_CYC = 2**26
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic term
);

   localparam int unsigned CW = $clog2(TERM_CYC + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (cnt != CW'(TERM_CYC)) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign term = (cnt == CW'(TERM_CYC));

endmodule

// File: rtl/cmd_arb.sv
// Shares the single cmd_cfg command port between host, aux and the
// host-silence failsafe; one command in flight, response routed to its owner.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | no command in flight; grant by priority fs > host > aux
// ISSUE     | cmd/data/cmd_rdy held until cmd_cfg pulses clr_cmd_rdy
// WAIT_RESP | waiting for send_resp; nack synthesised on timer expiry
module cmd_arb
   import quad_cmd_pkg::*;
#(
   parameter int unsigned WDOG_CYC     = 2**26,
   parameter int unsigned RESP_TMO_CYC = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  h_cmd,
   input  logic [15:0] h_data,
   input  logic        h_rdy,
   output logic        h_clr,
   output logic [7:0]  h_resp,
   output logic        h_resp_vld,
   input  logic [7:0]  a_cmd,
   input  logic [15:0] a_data,
   input  logic        a_rdy,
   output logic        a_clr,
   output logic [7:0]  a_resp,
   output logic        a_resp_vld,
   output logic [7:0]  cmd,
   output logic [15:0] data,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic        send_resp,
   input  logic [7:0]  resp,
   output logic        emer
);

   localparam int unsigned TW = $clog2(RESP_TMO_CYC + 1);

   arb_state_t    state;
   arb_state_t    state_nxt;
   owner_t        owner;
   owner_t        gnt;
   logic [TW-1:0] tmr;
   logic          hold;
   logic          wdog_term;
   logic          fs_req;
   logic          resp_done;
   logic [7:0]    resp_byte;

   cmd_wdog #(
      .TERM_CYC (WDOG_CYC)
   ) u_wdog (
      .clk  (clk),
      .rst  (rst),
      .clr  (h_rdy),
      .term (wdog_term)
   );

   // Once emer is latched the failsafe stays quiet until the host reappears.
   assign fs_req = wdog_term && !emer;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      gnt       = NONE;
      resp_done = 1'b0;
      resp_byte = NACK;
      case (state)
         IDLE: begin
            // hold keeps one idle cycle after each completed transaction
            if (!rst && !hold) begin
               if (fs_req) begin
                  gnt = FS;
               end else if (h_rdy) begin
                  gnt = HOST;
               end else if (a_rdy && !emer) begin
                  gnt = AUX;
               end
            end
            if (gnt != NONE) begin
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (clr_cmd_rdy) begin
               state_nxt = WAIT_RESP;
            end
         end
         WAIT_RESP: begin
            if (send_resp) begin
               resp_done = 1'b1;
               resp_byte = resp;
               state_nxt = IDLE;
            end else if (tmr == TW'(RESP_TMO_CYC)) begin
               resp_done = 1'b1;
               resp_byte = NACK;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign h_clr = (gnt == HOST);
   assign a_clr = (gnt == AUX);

   always_ff @(posedge clk) begin
      if (rst) begin
         owner      <= NONE;
         cmd        <= '0;
         data       <= '0;
         cmd_rdy    <= 1'b0;
         h_resp     <= '0;
         h_resp_vld <= 1'b0;
         a_resp     <= '0;
         a_resp_vld <= 1'b0;
         emer       <= 1'b0;
         tmr        <= '0;
         hold       <= 1'b0;
      end else begin
         h_resp_vld <= 1'b0;
         a_resp_vld <= 1'b0;
         hold       <= 1'b0;

         case (gnt)
            HOST: begin
               cmd  <= h_cmd;
               data <= h_data;
               emer <= 1'b0;
            end
            AUX: begin
               cmd  <= a_cmd;
               data <= a_data;
            end
            FS: begin
               cmd  <= EMER_LAND;
               data <= '0;
               emer <= 1'b1;
            end
            default: begin
            end
         endcase
         if (gnt != NONE) begin
            owner   <= gnt;
            cmd_rdy <= 1'b1;
         end

         if (state == ISSUE && clr_cmd_rdy) begin
            cmd_rdy <= 1'b0;
            tmr     <= '0;
         end

         if (state == WAIT_RESP) begin
            if (resp_done) begin
               hold  <= 1'b1;
               owner <= NONE;
               // failsafe-owned responses have nobody to go to
               if (owner == HOST) begin
                  h_resp     <= resp_byte;
                  h_resp_vld <= 1'b1;
               end else if (owner == AUX) begin
                  a_resp     <= resp_byte;
                  a_resp_vld <= 1'b1;
               end
            end else begin
               tmr <= tmr + TW'(1);
            end
         end
      end
   end

endmodule
